vn_mem_arbiter: RTL

//  Arbitrates the single shared byte-addressed RAM between the instruction-fetch port and the load/store port.

---
 rtl/vn_mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vn_mem_arbiter.sv
// vn_mem_arbiter: shares one byte-addressed RAM between the fetch port and the load/store port (build option MEM_ALIGN_CHECK_EN).
// Latency: a request granted at edge k uses the RAM in cycle k+1 and gets its rsp_valid pulse in cycle k+2. One access per 3 cycles.
// Backpressure: requesters hold req until rsp_valid. The losing port stays pending. Requests seen in DONE are ignored.
module vn_mem_arbiter #(
  parameter logic [31:0] START_ADDRESS = 32'd0,
  parameter logic [31:0] STOP_ADDRESS  = 32'd1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_mode,
  input  logic        d_unsigned,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_wr_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  mem_wr_mode,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_en,
  output logic [1:0]  mem_rd_mode,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {PORT_FETCH, PORT_DATA} port_t;

  state_t      state;
  port_t       rr_last;
  port_t       win_q;
  logic        we_q;
  logic [1:0]  code_q;
  logic        uns_q;
  logic        ok_q;

  port_t       win_c;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic [1:0]  sel_code;
  logic        sel_uns;
  logic [2:0]  size_c;
  logic [32:0] end_c;
  logic        ok_c;

  // Extend a sub-word load from the low bits of the RAM word.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] code, input logic uns);
    logic [31:0] r;
    case (code)
      2'b00:   r = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   r = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // Pick the winner (round robin on ties) and qualify its request.
  // The range check runs in 33 bits so an access cannot wrap past the top of the address space.
  always_comb begin
    win_c = PORT_FETCH;
    if (if_req && d_req) begin
      win_c = (rr_last == PORT_DATA) ? PORT_FETCH : PORT_DATA;
    end else if (d_req) begin
      win_c = PORT_DATA;
    end
    sel_addr  = if_addr;
    sel_wdata = 32'd0;
    sel_we    = 1'b0;
    sel_code  = 2'b11;
    sel_uns   = 1'b0;
    if (win_c == PORT_DATA) begin
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
      sel_we    = d_we;
      sel_uns   = d_unsigned;
      case (d_mode)
        2'b00:   sel_code = 2'b00;
        2'b01:   sel_code = 2'b01;
        default: sel_code = 2'b11;
      endcase
    end
    case (sel_code)
      2'b00:   size_c = 3'd1;
      2'b01:   size_c = 3'd2;
      default: size_c = 3'd4;
    endcase
    end_c = {1'b0, sel_addr} + {30'd0, size_c} - 33'd1;
    ok_c  = (({1'b0, sel_addr} + 33'd1) > {1'b0, START_ADDRESS}) &&
            (end_c <= {1'b0, STOP_ADDRESS});
`ifdef MEM_ALIGN_CHECK_EN
    if ((sel_code == 2'b01 && sel_addr[0]) || (sel_code == 2'b11 && sel_addr[1:0] != 2'b00)) begin
      ok_c = 1'b0;
    end
`endif
  end

  // Sequencer: grant and latch in IDLE, drive the RAM in ACCESS, pulse the winner's response in DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      rr_last      <= PORT_DATA;
      win_q        <= PORT_FETCH;
      we_q         <= 1'b0;
      code_q       <= 2'b00;
      uns_q        <= 1'b0;
      ok_q         <= 1'b0;
      if_rsp_valid <= 1'b0;
      if_rdata     <= 32'd0;
      if_err       <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rdata      <= 32'd0;
      d_err        <= 1'b0;
      mem_wr_addr  <= 32'd0;
      mem_wr_en    <= 1'b0;
      mem_wr_data  <= 32'd0;
      mem_wr_mode  <= 2'b00;
      mem_rd_addr  <= 32'd0;
      mem_rd_en    <= 1'b0;
      mem_rd_mode  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= ACCESS;
            rr_last <= win_c;
            win_q   <= win_c;
            we_q    <= sel_we;
            code_q  <= sel_code;
            uns_q   <= sel_uns;
            ok_q    <= ok_c;
            if (ok_c && sel_we) begin
              mem_wr_en   <= 1'b1;
              mem_wr_addr <= sel_addr;
              mem_wr_data <= sel_wdata;
              mem_wr_mode <= sel_code;
            end
            if (ok_c && !sel_we) begin
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= sel_addr;
              mem_rd_mode <= sel_code;
            end
          end
        end
        ACCESS: begin
          state       <= DONE;
          mem_wr_addr <= 32'd0;
          mem_wr_en   <= 1'b0;
          mem_wr_data <= 32'd0;
          mem_wr_mode <= 2'b00;
          mem_rd_addr <= 32'd0;
          mem_rd_en   <= 1'b0;
          mem_rd_mode <= 2'b00;
          if (win_q == PORT_FETCH) begin
            if_rsp_valid <= 1'b1;
            if_err       <= !ok_q;
            if_rdata     <= ok_q ? mem_rd_data : 32'd0;
          end else begin
            d_rsp_valid <= 1'b1;
            d_err       <= !ok_q;
            d_rdata     <= (ok_q && !we_q) ? extend(mem_rd_data, code_q, uns_q) : 32'd0;
          end
        end
        DONE: begin
          state        <= IDLE;
          if_rsp_valid <= 1'b0;
          d_rsp_valid  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
